// File: rtl/stream_mux_n_to_1_pkg.sv
// Shared definitions for the N-to-1 stream multiplexer: output-stage state
// encoding and the clog2 helper used to size channel select/index fields.
package stream_mux_pkg;

    // Output stage occupancy: EMPTY holds no word, FULL presents a word.
    typedef enum logic [0:0] {
        ST_EMPTY = 1'b0,
        ST_FULL  = 1'b1
    } state_t;

    // Ceiling log2, usable in constant expressions (parameters/localparams).
    function automatic int clog2_f(input int n);
        int r;
        r = 0;
        for (int i = 0; i < 31; i++) begin
            if ((32'sd1 << i) < n) begin
                r = i + 1;
            end else begin
                r = r;
            end
        end
        return r;
    endfunction

endpackage : stream_mux_pkg

// File: rtl/stream_mux_n_to_1_if.sv
// Bus bundle of the N-to-1 stream multiplexer: CHANNELS input streams,
// channel select/mode controls and the single registered output stream.
// slave  : the multiplexer side.
// master : the side driving inputs and consuming the output.
interface stream_mux_n_to_1_if
    import stream_mux_pkg::*;
#(
    parameter int WIDTH    = 5,
    parameter int CHANNELS = 4
);
    localparam int SEL_W = clog2_f(CHANNELS);

    logic [CHANNELS*WIDTH-1:0] in_data;
    logic [CHANNELS-1:0]       in_valid;
    logic [CHANNELS-1:0]       in_ready;
    logic [SEL_W-1:0]          sel;
    logic                      rr_mode;
    logic [WIDTH-1:0]          out_data;
    logic                      out_valid;
    logic                      out_ready;
    logic [SEL_W-1:0]          out_chan;

    modport slave (
        input  in_data,
        input  in_valid,
        output in_ready,
        input  sel,
        input  rr_mode,
        output out_data,
        output out_valid,
        input  out_ready,
        output out_chan
    );

    modport master (
        output in_data,
        output in_valid,
        input  in_ready,
        output sel,
        output rr_mode,
        input  out_data,
        input  out_valid,
        output out_ready,
        input  out_chan
    );

endinterface : stream_mux_n_to_1_if

// File: rtl/stream_mux_n_to_1_rr_arbiter.sv
// Combinational round-robin arbiter. Priority starts at the channel after
// last_grant and wraps modulo CHANNELS; the first requesting channel wins.
// No request means no grant (grant_valid=0, grant_oh all zero).
module rr_arbiter
    import stream_mux_pkg::*;
#(
    parameter int CHANNELS = 4,
    parameter int SEL_W    = clog2_f(CHANNELS)
) (
    input  logic [CHANNELS-1:0] req,
    input  logic [SEL_W-1:0]    last_grant,
    output logic [CHANNELS-1:0] grant_oh,
    output logic [SEL_W-1:0]    grant_idx,
    output logic                grant_valid
);

    int best_rank_s;
    int best_idx_s;

    // Rank every channel by distance after last_grant and keep the nearest requester.
    always_comb begin
        int rank;
        best_rank_s = CHANNELS;
        best_idx_s  = 0;
        for (int i = 0; i < CHANNELS; i++) begin
            rank = (i + CHANNELS - int'(last_grant) - 1) % CHANNELS;
            if (req[i] && (rank < best_rank_s)) begin
                best_rank_s = rank;
                best_idx_s  = i;
            end else begin
                best_rank_s = best_rank_s;
            end
        end
    end

    // Expand the winning index into one-hot and index grant outputs.
    always_comb begin
        grant_valid = (best_rank_s < CHANNELS);
        grant_idx   = SEL_W'(best_idx_s);
        grant_oh    = '0;
        for (int i = 0; i < CHANNELS; i++) begin
            grant_oh[i] = grant_valid && (best_idx_s == i);
        end
    end

endmodule : rr_arbiter

// File: rtl/stream_mux_n_to_1.sv
// N-to-1 valid/ready stream multiplexer with a single registered output
// stage (1-cycle latency, full throughput, full back-pressure).
// The granted channel comes from sel, or from a round-robin arbiter when
// built with MUX_RR_EN and rr_mode=1. Without MUX_RR_EN, rr_mode is ignored
// and no last-grant state exists.
// Reset is synchronous and active-high; it drops any held word.
module stream_mux_n_to_1
    import stream_mux_pkg::*;
#(
    parameter int WIDTH    = 5,
    parameter int CHANNELS = 4
) (
    input  logic                clk,
    input  logic                reset,
    stream_mux_n_to_1_if.slave  bus
);

    localparam int SEL_W = clog2_f(CHANNELS);

    state_t              state_r;
    logic                out_valid_r;
    logic [WIDTH-1:0]    out_data_r;
    logic [SEL_W-1:0]    out_chan_r;

    logic                space_s;
    logic                xfer_in_s;
    logic                sel_valid_s;
    logic [WIDTH-1:0]    sel_data_s;
    logic [CHANNELS-1:0] sel_oh_s;
    logic [CHANNELS-1:0] grant_oh_s;
    logic [SEL_W-1:0]    grant_idx_s;

    // Decode explicit select; out-of-range values (non-pow2 CHANNELS) select nothing.
    always_comb begin
        sel_oh_s = '0;
        for (int i = 0; i < CHANNELS; i++) begin
            sel_oh_s[i] = (bus.sel == SEL_W'(i));
        end
    end

`ifdef MUX_RR_EN
    logic [SEL_W-1:0]    last_grant_r;
    logic [CHANNELS-1:0] arb_oh_s;
    logic [SEL_W-1:0]    arb_idx_s;
    logic                arb_valid_s;

    rr_arbiter #(
        .CHANNELS (CHANNELS),
        .SEL_W    (SEL_W)
    ) u_rr_arbiter (
        .req         (bus.in_valid),
        .last_grant  (last_grant_r),
        .grant_oh    (arb_oh_s),
        .grant_idx   (arb_idx_s),
        .grant_valid (arb_valid_s)
    );

    // Pick the grant source; a mode change takes effect in the same cycle.
    always_comb begin
        if (bus.rr_mode) begin
            grant_oh_s  = arb_oh_s & {CHANNELS{arb_valid_s}};
            grant_idx_s = arb_idx_s;
        end else begin
            grant_oh_s  = sel_oh_s;
            grant_idx_s = bus.sel;
        end
    end

    // Remember the most recently accepted channel; kept across mode switches.
    always_ff @(posedge clk) begin
        if (reset) begin
            last_grant_r <= SEL_W'(CHANNELS - 1);
        end else if (xfer_in_s) begin
            last_grant_r <= grant_idx_s;
        end else begin
            last_grant_r <= last_grant_r;
        end
    end
`else
    logic unused_rr_mode_s;

    assign unused_rr_mode_s = bus.rr_mode;
    assign grant_oh_s       = sel_oh_s;
    assign grant_idx_s      = bus.sel;
`endif

    // The stage can take a word when empty or when its word leaves this cycle.
    assign space_s = (state_r == ST_EMPTY) | bus.out_ready;

    // Only the granted channel ever sees ready.
    assign bus.in_ready = grant_oh_s & {CHANNELS{space_s}};

    // AND-OR mux of the granted channel's data and valid.
    always_comb begin
        sel_data_s  = '0;
        sel_valid_s = 1'b0;
        for (int i = 0; i < CHANNELS; i++) begin
            sel_data_s  = sel_data_s | (bus.in_data[i*WIDTH +: WIDTH] & {WIDTH{grant_oh_s[i]}});
            sel_valid_s = sel_valid_s | (bus.in_valid[i] & grant_oh_s[i]);
        end
    end

    assign xfer_in_s = sel_valid_s & space_s;

    // Output stage FSM: load on transfer in, drain on transfer out, hold on stall.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r     <= ST_EMPTY;
            out_valid_r <= 1'b0;
            out_data_r  <= '0;
            out_chan_r  <= '0;
        end else begin
            case (state_r)
                ST_EMPTY: begin
                    if (xfer_in_s) begin
                        state_r     <= ST_FULL;
                        out_valid_r <= 1'b1;
                        out_data_r  <= sel_data_s;
                        out_chan_r  <= grant_idx_s;
                    end else begin
                        state_r     <= ST_EMPTY;
                        out_valid_r <= 1'b0;
                    end
                end
                ST_FULL: begin
                    if (xfer_in_s) begin
                        state_r     <= ST_FULL;
                        out_valid_r <= 1'b1;
                        out_data_r  <= sel_data_s;
                        out_chan_r  <= grant_idx_s;
                    end else if (bus.out_ready) begin
                        state_r     <= ST_EMPTY;
                        out_valid_r <= 1'b0;
                    end else begin
                        state_r     <= ST_FULL;
                        out_valid_r <= 1'b1;
                    end
                end
                default: begin
                    state_r     <= ST_EMPTY;
                    out_valid_r <= 1'b0;
                end
            endcase
        end
    end

    assign bus.out_valid = out_valid_r;
    assign bus.out_data  = out_data_r;
    assign bus.out_chan  = out_chan_r;

endmodule : stream_mux_n_to_1

// File: tb/tb_stream_mux_n_to_1.sv
// Directed self-checking bench for stream_mux_n_to_1 (4-channel and
// 3-channel instances, WIDTH=5). Round-robin scenarios apply when MUX_RR_EN
// is defined; otherwise the same scenarios confirm rr_mode is ignored.
module tb_stream_mux_n_to_1;

    logic clk;
    logic reset;
    int   errors;
    int   checks;

    stream_mux_n_to_1_if #(.WIDTH(5), .CHANNELS(4)) if4 ();
    stream_mux_n_to_1_if #(.WIDTH(5), .CHANNELS(3)) if3 ();

    stream_mux_n_to_1 #(.WIDTH(5), .CHANNELS(4)) dut4 (
        .clk   (clk),
        .reset (reset),
        .bus   (if4)
    );

    stream_mux_n_to_1 #(.WIDTH(5), .CHANNELS(3)) dut3 (
        .clk   (clk),
        .reset (reset),
        .bus   (if3)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set4(input int ch, input logic [4:0] val);
        if4.in_data[ch*5 +: 5] = val;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        if (if4.out_valid !== 1'b0) begin errors++; $display("FAIL reset_valid got=%b exp=0", if4.out_valid); end
        checks++;
        if (if4.out_data !== 5'h00) begin errors++; $display("FAIL reset_data got=%h exp=00", if4.out_data); end
        checks++;
        if (if4.out_chan !== 2'd0) begin errors++; $display("FAIL reset_chan got=%0d exp=0", if4.out_chan); end
        checks++;
        if (if3.out_valid !== 1'b0) begin errors++; $display("FAIL reset_valid3 got=%b exp=0", if3.out_valid); end
        checks++;
    endtask

    task automatic test_single();
        if4.sel = 2'd2; if4.in_valid = 4'b0100; set4(2, 5'h15); if4.out_ready = 1'b1;
        #1;
        if (if4.in_ready !== 4'b0100) begin errors++; $display("FAIL single_ready got=%b exp=0100", if4.in_ready); end
        checks++;
        tick();
        if4.in_valid = 4'b0000;
        if (if4.out_valid !== 1'b1 || if4.out_data !== 5'h15 || if4.out_chan !== 2'd2) begin
            errors++; $display("FAIL single_out got v=%b d=%h c=%0d exp v=1 d=15 c=2", if4.out_valid, if4.out_data, if4.out_chan);
        end
        checks++;
        tick();
        if (if4.out_valid !== 1'b0) begin errors++; $display("FAIL single_drain got=%b exp=0", if4.out_valid); end
        checks++;
    endtask

    task automatic test_explicit_idle();
        if4.sel = 2'd0; if4.in_valid = 4'b1110; if4.out_ready = 1'b1;
        #1;
        if (if4.in_ready !== 4'b0001) begin errors++; $display("FAIL idle_ready got=%b exp=0001", if4.in_ready); end
        checks++;
        tick();
        if (if4.out_valid !== 1'b0) begin errors++; $display("FAIL idle_valid got=%b exp=0", if4.out_valid); end
        checks++;
        if4.in_valid = 4'b0000;
    endtask

    task automatic test_stall();
        if4.sel = 2'd1; if4.in_valid = 4'b0010; set4(1, 5'h0A); if4.out_ready = 1'b0;
        tick();
        for (int k = 0; k < 3; k++) begin
            if4.sel = 2'(k);
            if4.in_valid = 4'b1111;
            if4.in_data = 20'(32'h5A5A3 * (k + 1));
            #1;
            if (if4.in_ready !== 4'b0000) begin errors++; $display("FAIL stall_ready cyc=%0d got=%b exp=0000", k, if4.in_ready); end
            checks++;
            tick();
            if (if4.out_valid !== 1'b1 || if4.out_data !== 5'h0A || if4.out_chan !== 2'd1) begin
                errors++; $display("FAIL stall_hold cyc=%0d got v=%b d=%h c=%0d exp v=1 d=0A c=1", k, if4.out_valid, if4.out_data, if4.out_chan);
            end
            checks++;
        end
        if4.sel = 2'd3; if4.in_valid = 4'b1000; set4(3, 5'h1C); if4.out_ready = 1'b1;
        #1;
        if (if4.in_ready !== 4'b1000) begin errors++; $display("FAIL release_ready got=%b exp=1000", if4.in_ready); end
        checks++;
        tick();
        if4.in_valid = 4'b0000;
        if (if4.out_valid !== 1'b1 || if4.out_data !== 5'h1C || if4.out_chan !== 2'd3) begin
            errors++; $display("FAIL release_out got v=%b d=%h c=%0d exp v=1 d=1C c=3", if4.out_valid, if4.out_data, if4.out_chan);
        end
        checks++;
        tick();
        if (if4.out_valid !== 1'b0) begin errors++; $display("FAIL release_nodup got=%b exp=0", if4.out_valid); end
        checks++;
    endtask

    task automatic test_back_to_back();
        if4.sel = 2'd1; if4.in_valid = 4'b0010; if4.out_ready = 1'b1;
        for (int k = 0; k < 8; k++) begin
            set4(1, 5'(k));
            tick();
            if (if4.out_valid !== 1'b1 || if4.out_data !== 5'(k) || if4.out_chan !== 2'd1) begin
                errors++; $display("FAIL b2b word=%0d got v=%b d=%h c=%0d exp v=1 d=%h c=1", k, if4.out_valid, if4.out_data, if4.out_chan, 5'(k));
            end
            checks++;
        end
        if4.in_valid = 4'b0000;
        tick();
        if (if4.out_valid !== 1'b0) begin errors++; $display("FAIL b2b_end got=%b exp=0", if4.out_valid); end
        checks++;
    endtask

    task automatic test_round_robin();
        logic [1:0] exp_chan [8];
        reset = 1'b1;
        tick();
        reset = 1'b0;
        for (int i = 0; i < 4; i++) set4(i, 5'(16 + i));
        if4.sel = 2'd2; if4.rr_mode = 1'b1; if4.out_ready = 1'b1; if4.in_valid = 4'b1111;
`ifdef MUX_RR_EN
        exp_chan = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd0, 2'd1, 2'd3, 2'd1};
`else
        exp_chan = '{2'd2, 2'd2, 2'd2, 2'd2, 2'd2, 2'd2, 2'd2, 2'd2};
`endif
        for (int k = 0; k < 8; k++) begin
            tick();
            if (if4.out_valid !== 1'b1 || if4.out_chan !== exp_chan[k] || if4.out_data !== (5'd16 + 5'(exp_chan[k]))) begin
                errors++; $display("FAIL rr step=%0d got v=%b c=%0d d=%h exp v=1 c=%0d", k, if4.out_valid, if4.out_chan, if4.out_data, exp_chan[k]);
            end
            checks++;
`ifdef MUX_RR_EN
            if (k == 4) if4.in_valid = 4'b1010;
`else
            if (k == 4) if4.in_valid = 4'b0110;
`endif
        end
        if4.rr_mode = 1'b0; if4.in_valid = 4'b0000;
        tick();
    endtask

    task automatic test_sel_range();
        if3.sel = 2'd3; if3.in_valid = 3'b111; if3.in_data = 15'h7FFF; if3.out_ready = 1'b1; if3.rr_mode = 1'b0;
        #1;
        if (if3.in_ready !== 3'b000) begin errors++; $display("FAIL range_ready got=%b exp=000", if3.in_ready); end
        checks++;
        tick();
        tick();
        if (if3.out_valid !== 1'b0) begin errors++; $display("FAIL range_valid got=%b exp=0", if3.out_valid); end
        checks++;
        if3.sel = 2'd2; if3.in_data = {5'h13, 5'h02, 5'h01};
        tick();
        if3.in_valid = 3'b000;
        if (if3.out_valid !== 1'b1 || if3.out_chan !== 2'd2 || if3.out_data !== 5'h13) begin
            errors++; $display("FAIL range_last got v=%b c=%0d d=%h exp v=1 c=2 d=13", if3.out_valid, if3.out_chan, if3.out_data);
        end
        checks++;
    endtask

    task automatic test_reset_stall();
        if4.rr_mode = 1'b0; if4.sel = 2'd0; if4.in_valid = 4'b0001; set4(0, 5'h07); if4.out_ready = 1'b0;
        tick();
        if4.in_valid = 4'b0000;
        tick();
        if (if4.out_valid !== 1'b1 || if4.out_data !== 5'h07) begin
            errors++; $display("FAIL rststall_hold got v=%b d=%h exp v=1 d=07", if4.out_valid, if4.out_data);
        end
        checks++;
        reset = 1'b1;
        tick();
        reset = 1'b0;
        if (if4.out_valid !== 1'b0 || if4.out_data !== 5'h00) begin
            errors++; $display("FAIL rststall_drop got v=%b d=%h exp v=0 d=00", if4.out_valid, if4.out_data);
        end
        checks++;
        if4.rr_mode = 1'b1; if4.sel = 2'd1; if4.in_valid = 4'b1111; if4.out_ready = 1'b1;
        tick();
        if4.in_valid = 4'b0000; if4.rr_mode = 1'b0;
`ifdef MUX_RR_EN
        if (if4.out_valid !== 1'b1 || if4.out_chan !== 2'd0) begin
            errors++; $display("FAIL rststall_rr got v=%b c=%0d exp v=1 c=0", if4.out_valid, if4.out_chan);
        end
`else
        if (if4.out_valid !== 1'b1 || if4.out_chan !== 2'd1) begin
            errors++; $display("FAIL rststall_sel got v=%b c=%0d exp v=1 c=1", if4.out_valid, if4.out_chan);
        end
`endif
        checks++;
    endtask

    initial begin
        errors = 0;
        checks = 0;
        reset = 1'b1;
        if4.in_data = '0; if4.in_valid = '0; if4.sel = '0; if4.rr_mode = 1'b0; if4.out_ready = 1'b0;
        if3.in_data = '0; if3.in_valid = '0; if3.sel = '0; if3.rr_mode = 1'b0; if3.out_ready = 1'b0;
        tick();
        test_reset();
        test_single();
        test_explicit_idle();
        test_stall();
        test_back_to_back();
        test_round_robin();
        test_sel_range();
        test_reset_stall();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule : tb_stream_mux_n_to_1
